hack_mem_arbiter: RTL and testbench
===================================

# hack_mem_arbiter

Arbiter that shares the single-port Hack data memory between the CPU data port and a second requester, a DMA engine used for screen scanout and keyboard/host loads. It sits between the CPU/DMA and the Memory block. It issues at most one memory access per cycle and steers read data back to the port that issued the read. The CPU has priority, so the CPU stalls whenever its grant is withheld. An optional starvation guard bounds how long DMA can be held off.

## Interface
Parameters:
- ADDR_W, 15, word address width into data memory
- DATA_W, 16, data word width
- MAX_WAIT, 4, consecutive denied DMA cycles before a forced DMA grant (range 1..15)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU requests an access this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle; low while cpu_req is high means the CPU stalls
- cpu_rvalid  out  1  cpu_rdata is valid
- cpu_rdata  out  DATA_W  read data for the CPU
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata  same directions, widths and meanings as the cpu_* ports, for the DMA port
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; registered, valid one cycle after the address is presented

## Operation
- Arbitration each cycle. Grants depend on req and registered state only; they are mutually exclusive.
  - force_dma set and dma_req high -> DMA is granted.
  - Otherwise cpu_req high -> CPU is granted.
  - Otherwise dma_req high -> DMA is granted.
  - No request -> no grant.
- Memory command:
  - mem_addr, mem_we and mem_wdata are muxed from the granted port.
  - With no grant: mem_we = 0 and mem_addr holds its previous value (registered hold).
- Read return:
  - A granted read sets the registered rd_owner and rd_pending.
  - The next cycle, the owner's rvalid pulses for 1 cycle and its rdata = mem_rdata.
  - The non-owner's rdata is driven 0.
  - Writes never produce rvalid.
- Requester rule: req, we, addr and wdata must be held stable until gnt. A requester drops req, or presents a new request, in the cycle after gnt.
- Back-to-back: a port may be granted on consecutive cycles. Reads pipeline: read N data returns in the same cycle read N+1 is issued.
- Starvation counter:
  - wait_cnt increments on every cycle with dma_req && !dma_gnt; it saturates at MAX_WAIT.
  - wait_cnt clears on dma_gnt or when dma_req is low.
  - force_dma = (wait_cnt == MAX_WAIT).
- Simultaneous write and read to the same address from different ports: served in grant order. No forwarding is needed because the memory is single-port.
- Reset:
  - cpu_gnt and dma_gnt are 0, mem_we = 0, mem_addr = 0.
  - Both rvalid = 0, both rdata = 0.
  - wait_cnt = 0, rd_pending = 0.
  - A read granted in the cycle reset rises returns no rvalid.

## Timing
- Grant latency: 0 cycles (same cycle as req when the port wins).
- Read latency: 1 cycle from gnt to rvalid.
- Write latency: committed at the edge ending the grant cycle.
- Worst-case DMA wait with the guard enabled: MAX_WAIT cycles, then granted on cycle MAX_WAIT+1 of continuous denial.
- Worst-case CPU stall: 1 cycle per forced DMA grant.
- Throughput: 1 access per cycle.

## Configuration
- HACK_ARB_STARVE_GUARD_EN defined: wait_cnt and force_dma are present as described above.
- Not defined: strict CPU priority. wait_cnt and force_dma are removed (force_dma tied to 0), and DMA can starve indefinitely. MAX_WAIT is ignored.

## Structure
- Shared package hack_bus_pkg:
  - ADDR_W and DATA_W constants
  - port-id typedef (PORT_CPU = 0, PORT_DMA = 1) used for rd_owner
  - MAX_WAIT default
- One sub-module, hack_starve_counter: the saturating wait counter with clear and force output. It is instantiated only under HACK_ARB_STARVE_GUARD_EN.

## Test plan
- Reset handling: reset high for 2 cycles with cpu_req = dma_req = 1 -> both gnt = 0, mem_we = 0, mem_addr = 0, rvalid = 0. First cycle after reset -> cpu_gnt = 1.
- CPU write then read: CPU writes 0x1234 to address 0x0010, then reads 0x0010 -> cpu_gnt on both cycles, cpu_rvalid in the 3rd cycle with cpu_rdata = 0x1234, dma_rvalid = 0.
- Contention: cpu_req and dma_req both held with distinct reads from cycle 0 -> CPU granted every cycle.
  - With the guard (MAX_WAIT = 4): DMA granted in cycle 4, the CPU stalls 1 cycle, and the DMA read data returns tagged to DMA in cycle 5.
  - Without the guard: DMA is never granted over 100 cycles.
- Interleaved reads: CPU read at 0x4000 granted in cycle N, DMA read at 0x6000 granted in cycle N+1 -> cpu_rvalid in N+1 and dma_rvalid in N+2, each carrying its own memory word.
- Reset mid-operation: DMA read granted in cycle N, reset asserted in cycle N+1 -> dma_rvalid stays 0 and wait_cnt = 0 after reset.
- Idle: no requests for 10 cycles -> mem_we = 0 throughout and mem_addr holds its last value.

Source files
------------

// File: rtl/hack_bus_pkg.sv
`default_nettype none
// =============================================================================
// hack_bus_pkg : shared widths and port ids for the Hack data-memory bus
// Revision: 1.0
// =============================================================================
package hack_bus_pkg;

  localparam int HACK_ADDR_W   = 15;
  localparam int HACK_DATA_W   = 16;
  localparam int HACK_MAX_WAIT = 4;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_id_e;

endpackage
`default_nettype wire

// File: rtl/hack_starve_counter.sv
`default_nettype none
// =============================================================================
// hack_starve_counter : saturating DMA wait counter with clear and force output
// Revision: 1.0
// =============================================================================
module hack_starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic force_o
);

  localparam logic [3:0] C_MAX = 4'(MAX_WAIT);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (inc_i && (cnt_q != C_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/hack_mem_arbiter.sv
`default_nettype none
// =============================================================================
// hack_mem_arbiter : CPU-priority arbiter sharing the single-port Hack data
//                    memory with a DMA port; HACK_ARB_STARVE_GUARD_EN adds the
//                    DMA starvation guard
// Revision: 1.0
// =============================================================================
module hack_mem_arbiter #(
  parameter int ADDR_W   = hack_bus_pkg::HACK_ADDR_W,
  parameter int DATA_W   = hack_bus_pkg::HACK_DATA_W,
  parameter int MAX_WAIT = hack_bus_pkg::HACK_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import hack_bus_pkg::*;

  logic              force_dma;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              rd_pending_q, rd_pending_d;
  port_id_e          rd_owner_q, rd_owner_d;

`ifdef HACK_ARB_STARVE_GUARD_EN
  hack_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (dma_req && !dma_gnt),
    .clr_i   (!dma_req || dma_gnt),
    .force_o (force_dma)
  );
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT == 0);
  assign force_dma       = 1'b0;
`endif

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (force_dma && dma_req) begin
        dma_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  // Without a grant the address bus parks on the last presented address.
  always_comb begin
    mem_addr     = mem_addr_q;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    rd_pending_d = 1'b0;
    rd_owner_d   = rd_owner_q;
    if (reset) begin
      mem_addr = '0;
    end else if (cpu_gnt) begin
      mem_addr     = cpu_addr;
      mem_we       = cpu_we;
      mem_wdata    = cpu_wdata;
      rd_pending_d = !cpu_we;
      rd_owner_d   = PORT_CPU;
    end else if (dma_gnt) begin
      mem_addr     = dma_addr;
      mem_we       = dma_we;
      mem_wdata    = dma_wdata;
      rd_pending_d = !dma_we;
      rd_owner_d   = PORT_DMA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q   <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= PORT_CPU;
    end else begin
      mem_addr_q   <= mem_addr;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Reset masks a read still in flight so no stale data escapes.
  always_comb begin
    cpu_rvalid = !reset && rd_pending_q && (rd_owner_q == PORT_CPU);
    dma_rvalid = !reset && rd_pending_q && (rd_owner_q == PORT_DMA);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dma_rdata  = dma_rvalid ? mem_rdata : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_hack_mem_arbiter.sv
`default_nettype none
// =============================================================================
// tb_hack_mem_arbiter : directed self-checking bench with read scoreboard
// Revision: 1.0
// =============================================================================
module tb_hack_mem_arbiter;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 4;
`ifdef HACK_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic              port;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr, mem_addr, last_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic              cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;

  exp_t              sb[$];
  logic [DATA_W-1:0] ref_mem [int];
  int                n_cmp = 0;
  int                n_err = 0;
  int                ncyc;
  logic              exp_d;

  always #5 clk = ~clk;

  hack_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} * 16'd7) ^ 16'h5A5A;
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pat(a);
  endfunction

  logic [DATA_W-1:0] wmem [0:32767];
  bit                wvld [0:32767];
  always @(posedge clk) begin
    if (mem_we) begin
      wmem[mem_addr] <= mem_wdata;
      wvld[mem_addr] <= 1'b1;
    end
    mem_rdata <= wvld[mem_addr] ? wmem[mem_addr] : pat(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic ecg, input logic edg);
    exp_t e;
    @(negedge clk);
    chk({tag, " cpu_gnt"}, cpu_gnt, ecg);
    chk({tag, " dma_gnt"}, dma_gnt, edg);
    if (ecg) begin
      chk({tag, " mem_addr"}, mem_addr, cpu_addr);
      chk({tag, " mem_we"}, mem_we, cpu_we);
      if (cpu_we) chk({tag, " mem_wdata"}, mem_wdata, cpu_wdata);
      last_addr = cpu_addr;
    end else if (edg) begin
      chk({tag, " mem_addr"}, mem_addr, dma_addr);
      chk({tag, " mem_we"}, mem_we, dma_we);
      if (dma_we) chk({tag, " mem_wdata"}, mem_wdata, dma_wdata);
      last_addr = dma_addr;
    end else begin
      chk({tag, " mem_addr_hold"}, mem_addr, last_addr);
      chk({tag, " mem_we_idle"}, mem_we, 1'b0);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, " cpu_rvalid"}, cpu_rvalid, e.port == 1'b0);
      chk({tag, " dma_rvalid"}, dma_rvalid, e.port == 1'b1);
      chk({tag, " cpu_rdata"}, cpu_rdata, (e.port == 1'b0) ? e.data : 16'h0);
      chk({tag, " dma_rdata"}, dma_rdata, (e.port == 1'b1) ? e.data : 16'h0);
    end else begin
      chk({tag, " cpu_rvalid"}, cpu_rvalid, 1'b0);
      chk({tag, " dma_rvalid"}, dma_rvalid, 1'b0);
      chk({tag, " cpu_rdata"}, cpu_rdata, 16'h0);
      chk({tag, " dma_rdata"}, dma_rdata, 16'h0);
    end
    if (ecg && !cpu_we) sb.push_back('{1'b0, ref_rd(cpu_addr)});
    if (edg && !dma_we) sb.push_back('{1'b1, ref_rd(dma_addr)});
    if (ecg && cpu_we) ref_mem[int'(cpu_addr)] = cpu_wdata;
    if (edg && dma_we) ref_mem[int'(dma_addr)] = dma_wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 15'h0010;
    cpu_wdata = 16'h0;
    dma_req   = 1'b1;
    dma_we    = 1'b0;
    dma_addr  = 15'h0020;
    dma_wdata = 16'h0;
    last_addr = '0;

    step("reset0", 1'b0, 1'b0);
    step("reset1", 1'b0, 1'b0);
    reset = 1'b0;
    step("post_rst", 1'b1, 1'b0);

    dma_req   = 1'b0;
    cpu_we    = 1'b1;
    cpu_wdata = 16'h1234;
    step("cpu_wr", 1'b1, 1'b0);
    cpu_we = 1'b0;
    step("cpu_rd", 1'b1, 1'b0);
    cpu_req = 1'b0;
    step("cpu_rd_ret", 1'b0, 1'b0);

    cpu_req  = 1'b1;
    cpu_addr = 15'h4000;
    step("il_cpu", 1'b1, 1'b0);
    cpu_req  = 1'b0;
    dma_req  = 1'b1;
    dma_addr = 15'h6000;
    step("il_dma", 1'b0, 1'b1);
    dma_req = 1'b0;
    for (int i = 0; i < 10; i++) step($sformatf("idle%0d", i), 1'b0, 1'b0);

    dma_req  = 1'b1;
    dma_addr = 15'h0200;
    step("mid_dma", 1'b0, 1'b1);
    cpu_req   = 1'b1;
    cpu_addr  = 15'h0100;
    reset     = 1'b1;
    sb.delete();
    last_addr = '0;
    step("mid_rst", 1'b0, 1'b0);
    reset = 1'b0;

    ncyc = GUARD ? 15 : 100;
    for (int i = 0; i < ncyc; i++) begin
      exp_d = GUARD && ((i % (MAX_WAIT + 1)) == MAX_WAIT);
      step($sformatf("contend%0d", i), !exp_d, exp_d);
      if (!exp_d) cpu_addr = cpu_addr + 15'd1;
    end

    cpu_req = 1'b0;
    dma_req = 1'b0;
    step("drain", 1'b0, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
